// File: rtl/xbar_pkg.sv
// Shared types for the RAM-port arbiter: simplified TL-UL channel structs,
// default sizing and the arbiter state encoding.
package xbar_pkg;

  localparam int RAM_ARB_M               = 2;
  localparam int RAM_ARB_MAX_OUTSTANDING = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/xbar_id_fifo.sv
// In-order FIFO of host indices: one entry per request accepted by the RAM
// and not yet answered; the head names the host owning the next D beat.
module xbar_id_fifo #(
  parameter int Depth = 4,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr;
  logic [PtrW-1:0]  r_rd;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == {CntW{1'b0}});
  assign head_o  = r_mem[r_rd];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr] <= data_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= {PtrW{1'b0}};
      r_rd  <= {PtrW{1'b0}};
      r_cnt <= {CntW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/xbar_ram_rr_arb.sv
// Round-robin M:1 TL-UL arbiter in front of the single RAM port, with A-channel
// grant lock, bounded outstanding requests and in-order D-channel routing.
module xbar_ram_rr_arb
  import xbar_pkg::*;
#(
  parameter int M              = RAM_ARB_M,
  parameter int MaxOutstanding = RAM_ARB_MAX_OUTSTANDING
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t [M-1:0] tl_h_i,
  output tl_d2h_t [M-1:0] tl_h_o,
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic    [M-1:0] grant_o,
  output logic            rsp_err_o
);
  localparam int IdxW = $clog2(M);
  localparam int D2hW = $bits(tl_d2h_t);

  arb_state_e      r_state;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_rr;
  logic            r_rst_d;

  logic            w_block;
  logic            w_req_any;
  logic            w_locked;
  logic            w_gvalid;
  logic            w_a_valid;
  logic            w_a_ready;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_d_beat;
  logic            w_d_ready;
  logic [IdxW-1:0] w_cand;
  logic [IdxW-1:0] w_pick;
  logic [IdxW-1:0] w_gidx;
  logic [IdxW-1:0] w_head;
  logic [M-1:0]    w_dv_h;
  logic [M-1:0]    w_ar_h;

  // Both the reset cycle and the one after it present a fully quiet interface.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rst_d <= 1'b1;
    end else begin
      r_rst_d <= 1'b0;
    end
  end

  assign w_block = rst_i | r_rst_d;

  // Scanning from the far end lets the requester closest to r_rr win last.
  always_comb begin
    w_req_any = 1'b0;
    w_pick    = r_rr;
    w_cand    = r_rr;
    for (int k = M - 1; k >= 0; k--) begin
      w_cand    = IdxW'((int'(r_rr) + k) % M);
      w_req_any = w_req_any | tl_h_i[w_cand].a_valid;
      w_pick    = tl_h_i[w_cand].a_valid ? w_cand : w_pick;
    end
  end

  assign w_locked  = (r_state == ARB_LOCKED);
  assign w_gidx    = w_locked ? r_lock_idx : w_pick;
  assign w_gvalid  = ~w_block & (w_locked | w_req_any);
  assign w_a_valid = w_gvalid & tl_h_i[w_gidx].a_valid;
  assign w_a_ready = w_gvalid & tl_d_i.a_ready & ~w_full;
  assign w_accept  = w_a_valid & w_a_ready;
  assign grant_o   = w_gvalid ? (M'(1) << w_gidx) : {M{1'b0}};

  xbar_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_accept),
    .data_i  (w_gidx),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // An empty FIFO swallows stray D beats so the RAM never stalls on them.
  assign w_d_ready = w_block ? 1'b0 : (w_empty ? 1'b1 : tl_h_i[w_head].d_ready);
  assign w_d_beat  = ~w_block & ~w_empty & tl_d_i.d_valid;
  assign w_pop     = w_d_beat & tl_h_i[w_head].d_ready;
  assign rsp_err_o = ~w_block & w_empty & tl_d_i.d_valid;

  always_comb begin
    tl_d_o         = tl_h_i[w_gidx];
    tl_d_o.a_valid = w_a_valid;
    tl_d_o.d_ready = w_d_ready;
  end

  // d_valid is the MSB and a_ready the LSB of tl_d2h_t; the rest is broadcast.
  for (genvar h = 0; h < M; h++) begin : g_host
    assign w_dv_h[h] = w_d_beat & (w_head == IdxW'(h));
    assign w_ar_h[h] = w_a_ready & (w_gidx == IdxW'(h));
    assign tl_h_o[h] = {w_dv_h[h], tl_d_i[D2hW-2:1], w_ar_h[h]};
  end

  // Arbiter: lock the grant while a request waits, advance rr past each winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ARB_IDLE;
      r_lock_idx <= {IdxW{1'b0}};
      r_rr       <= {IdxW{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_a_valid & ~w_accept) begin
            r_state    <= ARB_LOCKED;
            r_lock_idx <= w_gidx;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          if (w_accept) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_LOCKED;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (w_accept) begin
        r_rr <= (w_gidx == IdxW'(M - 1)) ? {IdxW{1'b0}} : w_gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xbar_ram_rr_arb.sv
// Bench for xbar_ram_rr_arb: directed scenarios then random traffic, all checked
// against a transaction-level model (queues of outstanding hosts and responses).
module tb_xbar_ram_rr_arb;
  import xbar_pkg::*;

  localparam int          NH   = 2;
  localparam int          MAXO = 4;
  localparam logic [31:0] KEY  = 32'h5A5A_0000;

  logic              clk = 1'b0;
  logic              rst;
  tl_h2d_t [NH-1:0]  tl_h_i;
  tl_d2h_t [NH-1:0]  tl_h_o;
  tl_h2d_t           tl_d_o;
  tl_d2h_t           tl_d_i;
  logic    [NH-1:0]  grant_o;
  logic              rsp_err_o;

  xbar_ram_rr_arb #(.M(NH), .MaxOutstanding(MAXO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tl_h_i    (tl_h_i),
    .tl_h_o    (tl_h_o),
    .tl_d_o    (tl_d_o),
    .tl_d_i    (tl_d_i),
    .grant_o   (grant_o),
    .rsp_err_o (rsp_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NH-1:0] h_av;
  logic [NH-1:0] h_dr;
  logic [31:0]   h_addr [NH];
  logic          ram_ar;
  logic          ram_dv;
  logic [31:0]   ram_data;
  int            ram_mode;
  bit            rand_mode;
  bit            auto_drop;

  int            m_rr;
  int            m_lock_g;
  bit            m_locked;
  bit            m_rst_prev;
  int            m_q[$];
  logic [31:0]   ram_q[$];
  typedef struct {int id; logic [31:0] addr;} rsp_t;
  rsp_t          exp_rsp_q[$];
  int            rsp_cnt [NH];

  logic [NH-1:0] obs_grant, obs_ar, obs_dv;
  logic          obs_avalid, obs_dready, obs_err;
  logic [31:0]   obs_addr;
  logic [31:0]   obs_ddata [NH];
  logic [31:0]   lock_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare at negedge against the model, advance the model.
  task automatic cycle();
    int            g;
    bit            blk, full, acc, pop;
    logic [NH-1:0] e_grant, e_ar, e_dv;
    logic          e_avalid, e_dr, e_err;
    rsp_t          r;
    if (rand_mode) begin
      for (int h = 0; h < NH; h++)
        if (!h_av[1'(h)] && $urandom_range(0, 2) != 0) h_av[1'(h)] = 1'b1;
      h_dr   = NH'($urandom_range(0, (1 << NH) - 1));
      ram_ar = ($urandom_range(0, 3) != 0);
    end
    if (ram_mode == 1) ram_dv = (ram_q.size() != 0);
    else if (ram_mode == 2) ram_dv = (ram_q.size() != 0) && ($urandom_range(0, 1) == 1);
    ram_data = (ram_q.size() != 0) ? (ram_q[0] ^ KEY) : 32'hDEAD_BEEF;
    for (int h = 0; h < NH; h++) begin
      tl_h_i[1'(h)]           = '0;
      tl_h_i[1'(h)].a_valid   = h_av[1'(h)];
      tl_h_i[1'(h)].a_opcode  = 3'd4;
      tl_h_i[1'(h)].a_source  = 8'(h);
      tl_h_i[1'(h)].a_address = h_addr[h];
      tl_h_i[1'(h)].d_ready   = h_dr[1'(h)];
    end
    tl_d_i         = '0;
    tl_d_i.a_ready = ram_ar;
    tl_d_i.d_valid = ram_dv;
    tl_d_i.d_data  = ram_data;

    @(negedge clk);
    obs_grant  = grant_o;
    obs_avalid = tl_d_o.a_valid;
    obs_addr   = tl_d_o.a_address;
    obs_dready = tl_d_o.d_ready;
    obs_err    = rsp_err_o;
    for (int h = 0; h < NH; h++) begin
      obs_ar[1'(h)] = tl_h_o[1'(h)].a_ready;
      obs_dv[1'(h)] = tl_h_o[1'(h)].d_valid;
      obs_ddata[h]  = tl_h_o[1'(h)].d_data;
    end

    blk = rst || m_rst_prev;
    g = -1; full = 0; acc = 0; pop = 0;
    e_grant = '0; e_ar = '0; e_dv = '0; e_avalid = 1'b0; e_dr = 1'b0; e_err = 1'b0;
    if (!blk) begin
      if (m_locked) g = m_lock_g;
      else
        for (int k = 0; k < NH; k++)
          if (g < 0 && h_av[1'((m_rr + k) % NH)]) g = (m_rr + k) % NH;
      full = (m_q.size() == MAXO);
      if (g >= 0) begin
        e_grant[1'(g)] = 1'b1;
        e_avalid       = h_av[1'(g)];
        e_ar[1'(g)]    = ram_ar && !full;
      end
      acc = e_avalid && ram_ar && !full;
      if (m_q.size() == 0) begin
        e_dr  = 1'b1;
        e_err = ram_dv;
      end else begin
        e_dv[1'(m_q[0])] = ram_dv;
        e_dr             = h_dr[1'(m_q[0])];
        pop              = ram_dv && e_dr;
      end
    end
    check("grant", 64'(obs_grant), 64'(e_grant));
    check("a_valid", 64'(obs_avalid), 64'(e_avalid));
    check("a_ready", 64'(obs_ar), 64'(e_ar));
    check("d_valid", 64'(obs_dv), 64'(e_dv));
    check("d_ready", 64'(obs_dready), 64'(e_dr));
    check("rsp_err", 64'(obs_err), 64'(e_err));
    if (e_avalid) check("a_address", 64'(obs_addr), 64'(h_addr[g]));
    for (int h = 0; h < NH; h++) begin
      if (obs_dv[1'(h)] && h_dr[1'(h)]) begin
        rsp_cnt[h]++;
        check("rsp_pending", 64'(exp_rsp_q.size() != 0), 64'd1);
        if (exp_rsp_q.size() != 0) begin
          r = exp_rsp_q.pop_front();
          check("rsp_owner", 64'(h), 64'(r.id));
          check("rsp_data", 64'(obs_ddata[h]), 64'(r.addr ^ KEY));
        end
      end
    end

    @(posedge clk);
    if (rst) begin
      m_q.delete();
      exp_rsp_q.delete();
      m_rr     = 0;
      m_locked = 0;
    end else if (!blk) begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(g);
        exp_rsp_q.push_back('{id: g, addr: h_addr[g]});
        ram_q.push_back(h_addr[g]);
        m_rr      = (g + 1) % NH;
        m_locked  = 0;
        h_addr[g] = h_addr[g] + 32'd4;
        if (auto_drop) h_av[1'(g)] = 1'b0;
      end else if (e_avalid) begin
        m_locked = 1;
        m_lock_g = g;
      end
    end
    if (ram_dv && obs_dready && ram_q.size() != 0) void'(ram_q.pop_front());
    m_rst_prev = rst;
    #1;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rand_mode = 0;
    h_av      = '0;
    h_dr      = '1;
    ram_mode  = 1;
    while (ram_q.size() != 0 && n < 16) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(ram_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; h_av = 2'b11; h_dr = 2'b11; ram_ar = 1'b1; ram_dv = 1'b0;
    h_addr[0] = 32'h0000_1000; h_addr[1] = 32'h0000_2000;
    ram_mode = 0; rand_mode = 0; auto_drop = 0;
    m_rr = 0; m_lock_g = 0; m_locked = 0; m_rst_prev = 0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;

    // Reset cycles and the quiet cycle after, with both hosts requesting
    cycle();
    check("rst_grant", 64'(obs_grant), 64'd0);
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_grant", 64'(obs_grant), 64'd0);
    check("post_rst_avalid", 64'(obs_avalid), 64'd0);
    check("post_rst_aready", 64'(obs_ar), 64'd0);

    // Both hosts streaming: grants alternate starting at host 0
    ram_mode = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("alt_grant%0d", i), 64'(obs_grant), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    drain();
    check("alt_rsp_h0", 64'(rsp_cnt[0]), 64'd4);
    check("alt_rsp_h1", 64'(rsp_cnt[1]), 64'd4);

    // Grant lock while RAM stalls
    ram_mode = 0; ram_dv = 1'b0; ram_ar = 1'b0; h_av = 2'b01;
    cycle();
    check("lock_grant0", 64'(obs_grant), 64'd1);
    lock_addr = obs_addr;
    h_av = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("lock_grant", 64'(obs_grant), 64'd1);
      check("lock_addr", 64'(obs_addr), 64'(lock_addr));
    end
    ram_ar = 1'b1;
    cycle();
    check("lock_accept", 64'(obs_ar), 64'd1);
    cycle();
    check("lock_next_grant", 64'(obs_grant), 64'd2);
    drain();

    // Host 1 alone fills the FIFO; pop and pending request in the same cycle
    ram_mode = 0; ram_dv = 1'b0; ram_ar = 1'b1; h_av = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fill_aready", 64'(obs_ar), 64'd2);
    end
    cycle();
    check("full_aready", 64'(obs_ar), 64'd0);
    check("full_grant", 64'(obs_grant), 64'd2);
    ram_dv = 1'b1;
    cycle();
    check("full_pop_aready", 64'(obs_ar), 64'd0);
    check("full_pop_dvalid", 64'(obs_dv), 64'd2);
    ram_dv = 1'b0;
    cycle();
    check("after_pop_aready", 64'(obs_ar), 64'd2);
    drain();

    // Unsolicited D beat
    ram_mode = 0; h_av = 2'b00; ram_dv = 1'b1;
    cycle();
    check("unsol_err", 64'(obs_err), 64'd1);
    check("unsol_dready", 64'(obs_dready), 64'd1);
    check("unsol_dvalid", 64'(obs_dv), 64'd0);
    ram_dv = 1'b0;
    cycle();
    check("unsol_err_end", 64'(obs_err), 64'd0);

    // Reset with three requests outstanding; late responses become errors
    h_av = 2'b11; ram_ar = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("mid_outstanding", 64'(ram_q.size()), 64'd3);
    h_av = 2'b00; rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("mid_rst_grant", 64'(obs_grant), 64'd0);
    check("mid_rst_dvalid", 64'(obs_dv), 64'd0);
    ram_dv = 1'b1;
    cycle();
    check("late_rsp_err", 64'(obs_err), 64'd1);
    check("late_rsp_dvalid", 64'(obs_dv), 64'd0);
    drain();

    // Random traffic against the model
    rand_mode = 1; auto_drop = 1; ram_mode = 2; h_av = '0;
    for (int i = 0; i < 400; i++) cycle();
    drain();
    check("final_model_empty", 64'(m_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
